cbus_arbiter: RTL and testbench



---
 rtl/cbus_arbiter_pkg.sv | 27 ++
 rtl/cbus_arbiter_if.sv | 12 +
 rtl/cbus_arb_pick.sv | 35 +++
 rtl/cbus_arbiter.sv | 58 +++++
 tb/tb_cbus_arbiter.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/cbus_arbiter_pkg.sv
// cbus_arbiter_pkg: CBus request/response types and arbiter state encoding.
package cbus_arbiter_pkg;
    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_type_t;

    typedef struct packed {
        logic            valid;
        logic            is_write;
        logic [2:0]      size;
        logic [31:0]     addr;
        logic [7:0]      strobe;
        logic [63:0]     data;
        logic [7:0]      len;
        axi_burst_type_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/cbus_arbiter_if.sv
// cbus_arbiter_if: upstream request/response arrays plus the single downstream CBus port.
interface cbus_arbiter_if
    import cbus_arbiter_pkg::*;
#(parameter int NUM_PORTS = 2);
    cbus_req_t  ireqs  [NUM_PORTS];
    cbus_resp_t iresps [NUM_PORTS];
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    modport slave  (input ireqs, oresp, output iresps, oreq);
    modport master (output ireqs, oresp, input iresps, oreq);
endinterface

// File: rtl/cbus_arb_pick.sv
// cbus_arb_pick: combinational winner select; round-robin when CBUS_ARB_RR_EN is defined,
// otherwise lowest-index fixed priority.
module cbus_arb_pick #(
    parameter  int NUM_PORTS = 2,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] valid,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic                 hit,
    output logic [IDX_W-1:0]     idx
);
`ifdef CBUS_ARB_RR_EN
    int best;
    always_comb begin
        hit  = |valid;
        idx  = '0;
        best = NUM_PORTS;
        // smallest upward distance from rr_ptr (with wrap) wins
        for (int j = 0; j < NUM_PORTS; j++)
            if (valid[j] && ((j - int'(rr_ptr) + NUM_PORTS) % NUM_PORTS) < best) begin
                best = (j - int'(rr_ptr) + NUM_PORTS) % NUM_PORTS;
                idx  = IDX_W'(j);
            end
    end
`else
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;
    always_comb begin
        hit = |valid;
        idx = '0;
        for (int j = NUM_PORTS - 1; j >= 0; j--)
            if (valid[j]) idx = IDX_W'(j);
    end
`endif
endmodule

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: N-to-1 CBus arbiter, grant held for a whole burst, 1-cycle grant latency.
// Arbitration policy selected by CBUS_ARB_RR_EN (round-robin) vs fixed priority.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(parameter int NUM_PORTS = 2) (
    input logic           clk,
    input logic           reset,
    cbus_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_PORTS);

    arb_state_t           state, state_n;
    logic [IDX_W-1:0]     sel, sel_n, rr_ptr, rr_ptr_n, win;
    logic [NUM_PORTS-1:0] valid;
    logic                 hit;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_valid
        assign valid[p] = bus.ireqs[p].valid;
    end

    cbus_arb_pick #(.NUM_PORTS(NUM_PORTS)) pick (
        .valid (valid),
        .rr_ptr(rr_ptr),
        .hit   (hit),
        .idx   (win)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            sel    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_n;
            sel    <= sel_n;
            rr_ptr <= rr_ptr_n;
        end
    end

    always_comb begin
        state_n  = state;
        sel_n    = sel;
        rr_ptr_n = rr_ptr;
        bus.oreq = '0;
        for (int i = 0; i < NUM_PORTS; i++) bus.iresps[i] = '0;
        if (state == IDLE) begin
            state_n = hit ? BUSY : IDLE;
            sel_n   = hit ? win : sel;
        end else begin
            bus.oreq        = bus.ireqs[sel];
            bus.iresps[sel] = bus.oresp;
            if (bus.oresp.ready && bus.oresp.last) begin
                state_n  = IDLE;
                rr_ptr_n = (sel == IDX_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed scenarios plus random traffic against a granted-port reference model.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;
    localparam int N = 2;

    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;

    cbus_arbiter_if #(.NUM_PORTS(N)) bus ();
    cbus_arbiter #(.NUM_PORTS(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0, passes = 0;
    int g = -1, rr = 0, beat = 0, wait_left = 0, max_lat = 2, bursts = 0;
    int done_port = -1, last_beats = 0;
    bit keep_valid = 0, stray = 0;
    int grants[$];

    function automatic cbus_req_t rand_req();
        cbus_req_t r;
        r.valid    = 1'b1;
        r.is_write = 1'($urandom);
        r.size     = 3'($urandom_range(0, 3));
        r.addr     = $urandom;
        r.strobe   = 8'($urandom);
        r.data     = {$urandom, $urandom};
        r.len      = 8'($urandom_range(0, 3));
        r.burst    = axi_burst_type_t'($urandom_range(0, 2));
        return r;
    endfunction

    // winner from the policy rules: scan ports in priority order
    function automatic int pick_model();
        for (int k = 0; k < N; k++) begin
            int i;
`ifdef CBUS_ARB_RR_EN
            i = (rr + k) % N;
`else
            i = k;
`endif
            if (bus.ireqs[i].valid) return i;
        end
        return -1;
    endfunction

    task automatic mem_drive();
        cbus_resp_t r;
        r = '0;
        if (stray && g < 0) begin
            r.ready = 1; r.last = 1; r.data = {$urandom, $urandom};
        end else if (g >= 0 && wait_left == 0) begin
            r.ready = 1;
            r.last  = (beat == int'(bus.ireqs[g].len));
            r.data  = {$urandom, $urandom};
        end
        bus.oresp = r;
    endtask

    task automatic check_outputs();
        cbus_req_t  er;
        cbus_resp_t ep;
        er = (g < 0) ? '0 : bus.ireqs[g];
        checks++;
        assert (bus.oreq === er) passes++;
        else $error("FAIL oreq got %h exp %h", bus.oreq, er);
        for (int i = 0; i < N; i++) begin
            ep = (i == g) ? bus.oresp : '0;
            checks++;
            assert (bus.iresps[i] === ep) passes++;
            else $error("FAIL iresps[%0d] got %h exp %h", i, bus.iresps[i], ep);
        end
        checks++;
        assert (dut.state === ((g < 0) ? IDLE : BUSY)) passes++;
        else $error("FAIL state got %0d exp busy=%0d", dut.state, g >= 0);
    endtask

    task automatic model_update();
        done_port = -1;
        if (reset) begin
            g = -1; rr = 0; beat = 0; wait_left = 0;
        end else if (g < 0) begin
            int w;
            w = pick_model();
            if (w >= 0) begin g = w; grants.push_back(w); end
        end else if (bus.oresp.ready) begin
            if (bus.oresp.last) begin
                done_port = g; last_beats = beat + 1;
                rr = (g + 1) % N; g = -1; beat = 0; bursts++;
            end else beat++;
            wait_left = $urandom_range(0, max_lat);
        end else if (wait_left > 0) wait_left--;
    endtask

    task automatic cycle();
        #1 mem_drive();
        #2 check_outputs();
        @(posedge clk);
        model_update();
        #1;
        if (done_port >= 0 && !keep_valid) bus.ireqs[done_port].valid = 1'b0;
    endtask

    task automatic run_bursts(input int target, input int budget);
        int start, c;
        start = bursts; c = 0;
        while (bursts < start + target && c < budget) begin cycle(); c++; end
        checks++;
        assert (bursts >= start + target) passes++;
        else $error("FAIL burst_timeout got %0d exp %0d", bursts - start, target);
    endtask

    initial begin
        int n0, c, exp_g;
        bus.ireqs[0] = '0; bus.ireqs[1] = '0; bus.oresp = '0;
        @(posedge clk); #1;
        repeat (2) cycle();
        reset = 0;
        stray = 1; repeat (2) cycle(); stray = 0;
        // single read on port 0
        bus.ireqs[0] = rand_req();
        bus.ireqs[0].is_write = 0; bus.ireqs[0].size = 3; bus.ireqs[0].addr = 32'h8000_0000;
        bus.ireqs[0].len = 3; bus.ireqs[0].burst = AXI_BURST_INCR;
        run_bursts(1, 60);
        checks++;
        assert (last_beats === 4) passes++;
        else $error("FAIL single_beats got %0d exp 4", last_beats);
        cycle();
        // contention with continuous valid, single-beat bursts
        keep_valid = 1;
        bus.ireqs[0] = rand_req(); bus.ireqs[0].len = 0;
        bus.ireqs[1] = rand_req(); bus.ireqs[1].len = 0;
        n0 = grants.size();
        run_bursts(4, 100);
        for (int k = 0; k < 4; k++) begin
`ifdef CBUS_ARB_RR_EN
            exp_g = (1 + k) % 2;
`else
            exp_g = 0;
`endif
            checks++;
            assert (grants[n0 + k] === exp_g) passes++;
            else $error("FAIL contention_grant%0d got %0d exp %0d", k, grants[n0 + k], exp_g);
        end
        keep_valid = 0;
        bus.ireqs[0].valid = 0;
        run_bursts(1, 20);
        checks++;
        assert (grants[$] === 1) passes++;
        else $error("FAIL port1_after_drop got %0d exp 1", grants[$]);
        // long-latency write on port 1
        bus.ireqs[1] = rand_req();
        bus.ireqs[1].is_write = 1; bus.ireqs[1].data = 64'h233; bus.ireqs[1].strobe = 8'hff;
        bus.ireqs[1].addr = 32'h2333_3000; bus.ireqs[1].len = 3;
        max_lat = 31; wait_left = 31;
        run_bursts(1, 400);
        max_lat = 2;
        // reset while beat 2 of a len=7 read is pending
        bus.ireqs[0] = rand_req(); bus.ireqs[0].is_write = 0; bus.ireqs[0].len = 7;
        c = 0;
        while (!(g >= 0 && beat == 2) && c < 100) begin cycle(); c++; end
        checks++;
        assert (c < 100) passes++;
        else $error("FAIL reach_beat2 got %0d cycles exp <100", c);
        reset = 1; cycle(); reset = 0;
        run_bursts(1, 100);
        // random traffic with masters holding requests until served
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < N; i++)
                if (!bus.ireqs[i].valid && $urandom_range(0, 2) == 0) bus.ireqs[i] = rand_req();
            cycle();
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
